// File: rtl/sim_ctrl_ahbl.sv
// Simulation-control AHB-Lite slave: PASS/FAIL/character writes into a character FIFO,
// a status read-back word, and a retire-based watchdog that flags a hung CPU.
module sim_ctrl_ahbl #(
  parameter logic [31:0] CTRL_ADDR   = 32'h6000FFF8,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          WDOG_WINDOW = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  input  logic        retire,
  output logic        char_vld,
  output logic [7:0]  char_data,
  input  logic        char_rdy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout
);

  localparam int          AW  = $clog2(FIFO_DEPTH);
  localparam logic [31:0] WIN = 32'(WDOG_WINDOW);

  logic          acc, pend_wr, pend_rd;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          fifo_full, fifo_empty, push, pop;
  logic          is_pass, is_fail, wr_live, char_wr;
  logic          set_pass, set_fail, set_to, wdog_edge;
  logic [31:0]   cyc_cnt, ret_cnt;
  logic          unused;

  assign unused = htrans[0];

  assign acc = hsel && hready && htrans[1] && (haddr == CTRL_ADDR);

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop        = !fifo_empty && char_rdy;

  assign is_pass = (hwdata == 32'h00000FFF) || (hwdata == 32'hFFFF0000);
  assign is_fail = (hwdata == 32'h00000EEE) || (hwdata == 32'hEEEE0000);
  assign wr_live = pend_wr && !done;
  assign char_wr = wr_live && !is_pass && !is_fail;

  // A pop in the same cycle frees the slot, so a full FIFO only stalls without one.
  assign push      = char_wr && (!fifo_full || pop);
  assign hreadyout = !(char_wr && fifo_full && !pop);
  assign hresp     = 2'b00;
  assign hrdata    = pend_rd ? {27'b0, fifo_full, fifo_empty, timeout, fail, pass} : 32'b0;

  assign char_vld  = !fifo_empty;
  assign char_data = fifo_empty ? 8'h00 : mem[rptr[AW-1:0]];

  assign set_pass  = wr_live && is_pass;
  assign set_fail  = wr_live && is_fail;
  assign wdog_edge = (cyc_cnt == WIN);
  assign set_to    = !done && wdog_edge && (ret_cnt == 32'b0);

  // The pending flags only advance when our own data phase completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_wr <= 1'b0;
      pend_rd <= 1'b0;
    end else if (hreadyout) begin
      pend_wr <= acc && hwrite;
      pend_rd <= acc && !hwrite;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= hwdata[7:0];
  end

  // A retire in the boundary cycle seeds the next window's count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= 32'd1;
      ret_cnt <= 32'd0;
    end else if (!done) begin
      cyc_cnt <= wdog_edge ? 32'd1 : cyc_cnt + 32'd1;
      if (wdog_edge)
        ret_cnt <= {31'b0, retire};
      else if (retire && ret_cnt != 32'hFFFFFFFF)
        ret_cnt <= ret_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
      done    <= 1'b0;
    end else begin
      pass    <= pass    | set_pass;
      fail    <= fail    | set_fail;
      timeout <= timeout | set_to;
      done    <= done    | set_pass | set_fail | set_to;
    end
  end

endmodule

// File: tb/tb_sim_ctrl_ahbl.sv
// Directed bench for sim_ctrl_ahbl: character path, FIFO stall, PASS/FAIL, watchdog, reset.
module tb_sim_ctrl_ahbl;

  localparam logic [31:0] CA = 32'h6000FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'b0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = 32'b0;
  logic        hready;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        retire = 1'b0;
  logic        char_vld;
  logic [7:0]  char_data;
  logic        char_rdy = 1'b0;
  logic        done, pass, fail, timeout;

  int tests = 0;
  int fails = 0;
  logic [7:0] got_q [$];
  int vld_cycles = 0;

  assign hready = hreadyout;

  sim_ctrl_ahbl dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .retire(retire), .char_vld(char_vld), .char_data(char_data), .char_rdy(char_rdy),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (char_vld) vld_cycles <= vld_cycles + 1;
    if (char_vld && char_rdy) got_q.push_back(char_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'b0; retire = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives an address phase and returns at the negedge inside the data phase.
  task automatic addr_ph(input logic wr, input logic [31:0] data);
    @(negedge clk);
    hsel = 1'b1; haddr = CA; htrans = 2'b10; hwrite = wr;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = data;
  endtask

  task automatic ahb_wr(input logic [31:0] data);
    int n;
    addr_ph(1'b1, data);
    n = 0;
    while (!hreadyout && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wr_complete", {31'b0, hreadyout}, 32'd1);
  endtask

  initial begin
    // reset values while rst is held
    @(negedge clk);
    check("rst_hreadyout", {31'b0, hreadyout}, 32'd1);
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_status", {27'b0, char_vld, done, pass, fail, timeout}, 32'd0);
    check("rst_char_data", {24'b0, char_data}, 32'd0);
    check("hresp", {30'b0, hresp}, 32'd0);

    // two characters with the consumer always ready
    do_reset();
    char_rdy = 1'b1;
    got_q.delete(); vld_cycles = 0;
    ahb_wr(32'h48);
    ahb_wr(32'h69);
    repeat (4) @(negedge clk);
    check("hi_count", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      check("hi_c0", {24'b0, got_q[0]}, 32'h48);
      check("hi_c1", {24'b0, got_q[1]}, 32'h69);
    end
    check("hi_vld_cycles", vld_cycles, 32'd2);
    check("hi_done", {31'b0, done}, 32'd0);

    // fill FIFO with consumer stalled; 9th write must wait for a slot
    do_reset();
    char_rdy = 1'b0;
    got_q.delete();
    for (int i = 0; i < 8; i++) ahb_wr(32'h30 + i);
    addr_ph(1'b1, 32'h38);
    check("full_stall", {31'b0, hreadyout}, 32'd0);
    @(negedge clk);
    check("full_stall_hold", {31'b0, hreadyout}, 32'd0);
    check("full_head", {24'b0, char_data}, 32'h30);
    char_rdy = 1'b1;
    #1;
    check("full_release", {31'b0, hreadyout}, 32'd1);
    @(negedge clk);
    char_rdy = 1'b0;
    check("full_after_hready", {31'b0, hreadyout}, 32'd1);
    check("full_after_vld", {31'b0, char_vld}, 32'd1);
    char_rdy = 1'b1;
    repeat (12) @(negedge clk);
    check("full_drain_count", got_q.size(), 32'd9);
    for (int i = 0; i < 9; i++)
      if (i < got_q.size()) check("full_order", {24'b0, got_q[i]}, 32'h30 + i);
    check("full_empty_after", {31'b0, char_vld}, 32'd0);

    // PASS, then writes ignored, then status read (empty=bit3, pass=bit0)
    do_reset();
    char_rdy = 1'b1;
    got_q.delete();
    ahb_wr(32'hFFFF0000);
    check("pass_not_yet", {31'b0, pass}, 32'd0);
    @(negedge clk);
    check("pass_set", {31'b0, pass}, 32'd1);
    check("pass_done", {31'b0, done}, 32'd1);
    ahb_wr(32'h41);
    ahb_wr(32'h00000EEE);
    repeat (3) @(negedge clk);
    check("pass_no_push", got_q.size(), 32'd0);
    check("pass_fail_ignored", {31'b0, fail}, 32'd0);
    addr_ph(1'b0, 32'h0);
    check("pass_read", hrdata, 32'h00000009);
    @(negedge clk);
    check("read_idle", hrdata, 32'd0);

    // FAIL, with alternate encoding afterwards ignored
    do_reset();
    ahb_wr(32'h00000EEE);
    @(negedge clk);
    check("fail_status", {28'b0, done, pass, fail, timeout}, 32'b1010);
    ahb_wr(32'h00000FFF);
    @(negedge clk);
    check("fail_pass_ignored", {31'b0, pass}, 32'd0);
    addr_ph(1'b0, 32'h0);
    check("fail_read", hrdata, 32'h0000000A);

    // watchdog with no retirement: trips after exactly WDOG_WINDOW edges
    do_reset();
    repeat (4999) @(posedge clk);
    #1;
    check("wdog_before", {31'b0, timeout}, 32'd0);
    @(posedge clk);
    #1;
    check("wdog_timeout", {31'b0, timeout}, 32'd1);
    check("wdog_done", {31'b0, done}, 32'd1);
    addr_ph(1'b0, 32'h0);
    check("wdog_read", hrdata, 32'h0000000C);

    // one retire every 4999 cycles keeps it alive over three windows
    do_reset();
    for (int i = 1; i <= 15100; i++) begin
      @(negedge clk);
      retire = (i % 4999 == 100);
    end
    @(negedge clk);
    retire = 1'b0;
    check("wdog_alive", {30'b0, timeout, done}, 32'd0);

    // reset during a stalled character write
    do_reset();
    char_rdy = 1'b0;
    got_q.delete();
    for (int i = 0; i < 8; i++) ahb_wr(32'h50 + i);
    addr_ph(1'b1, 32'h58);
    check("rst_mid_stall", {31'b0, hreadyout}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_hready", {31'b0, hreadyout}, 32'd1);
    check("rst_mid_vld", {31'b0, char_vld}, 32'd0);
    check("rst_mid_data", {24'b0, char_data}, 32'd0);
    @(negedge clk);
    hwdata = 32'b0;
    char_rdy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_no_char", got_q.size(), 32'd0);
    check("rst_mid_done", {31'b0, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
